// File: rtl/sym_tick_pkg.sv
// Shared definitions for the symbol/sample tick scheduler: FSM encoding,
// default field widths and the zero-to-one factor clamp.
package sym_tick_pkg;

  localparam int unsigned DIV_W_DEF = 13;
  localparam int unsigned SPS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A programmed factor of zero behaves exactly like a factor of one.
  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sym_tick_sched_mod_cnt.sv
// Modulo-N wrap counter with enable, synchronous clear and a wrap flag
// that is high on the enabled cycle where the count returns to zero.
module mod_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] mod_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_max;

  // mod_i is always >= 1 and only changes while the count is zero.
  assign at_max = (cnt_q == mod_i - W'(1));
  assign wrap_o = en_i && at_max;
  assign cnt_o  = cnt_q;

  // NOTE: next-state gets its default first so no branch can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sym_tick_sched.sv
// Sample/symbol clock-enable scheduler with start/stop and symbol-aligned
// reprogramming. Optional sticky underrun flag: SYM_TICK_SCHED_UNDERRUN_EN.
module sym_tick_sched
  import sym_tick_pkg::*;
#(
  parameter int unsigned      DIV_W   = DIV_W_DEF,
  parameter int unsigned      SPS_W   = SPS_W_DEF,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(4),
  parameter logic [SPS_W-1:0] DEF_SPS = SPS_W'(8)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [SPS_W-1:0] cfg_sps,
  output logic             sample_tick,
  output logic             symbol_tick,
`ifdef SYM_TICK_SCHED_UNDERRUN_EN
  input  logic             sym_data_valid,
  output logic             underrun,
`endif
  output logic             busy
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, pend_div_q, pend_div_d;
  logic [SPS_W-1:0]   sps_q, sps_d, pend_sps_q, pend_sps_d;
  logic               pend_valid_q, pend_valid_d;

  logic [DIV_W-1:0]   div_eff, div_cnt;
  logic [SPS_W-1:0]   sps_eff, sample_cnt;
  logic               run_act, cnt_clr, div_wrap, sample_wrap;
  logic               cfg_fire, leave_run, apply_pend;

  assign div_eff = DIV_W'(clamp_min1(32'(div_q)));
  assign sps_eff = SPS_W'(clamp_min1(32'(sps_q)));
  assign run_act = (state_q != IDLE);
  assign cnt_clr = (state_d == IDLE);

  mod_cnt #(.W(DIV_W)) u_div_cnt (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .en_i   (run_act),
    .clr_i  (cnt_clr),
    .mod_i  (div_eff),
    .cnt_o  (div_cnt),
    .wrap_o (div_wrap)
  );

  mod_cnt #(.W(SPS_W)) u_sample_cnt (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .en_i   (div_wrap),
    .clr_i  (cnt_clr),
    .mod_i  (sps_eff),
    .cnt_o  (sample_cnt),
    .wrap_o (sample_wrap)
  );

  assign sample_tick = run_act && (div_cnt == div_eff - DIV_W'(1));
  assign symbol_tick = sample_tick && (sample_cnt == '0);
  assign cfg_ready   = !pend_valid_q;
  assign busy        = run_act;
  assign cfg_fire    = cfg_valid && cfg_ready;

  // Stopping in RUN goes straight to IDLE only when no symbol is open after
  // this edge; a symbol started on this very edge is drained to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        if (!en) begin
          if (sample_wrap || (sample_cnt == '0 && !sample_tick)) state_d = IDLE;
          else                                                   state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (en)               state_d = RUN;
        else if (sample_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign leave_run  = run_act && (state_d == IDLE);
  assign apply_pend = pend_valid_q && (sample_wrap || leave_run);

  always_comb begin
    div_d        = div_q;
    sps_d        = sps_q;
    pend_div_d   = pend_div_q;
    pend_sps_d   = pend_sps_q;
    pend_valid_d = pend_valid_q;
    if (state_q == IDLE) begin
      if (cfg_fire) begin
        div_d = cfg_div;
        sps_d = cfg_sps;
      end
    end else begin
      // cfg_fire implies no pending entry, so these never collide.
      if (apply_pend) begin
        div_d        = pend_div_q;
        sps_d        = pend_sps_q;
        pend_valid_d = 1'b0;
      end
      if (cfg_fire) begin
        pend_div_d   = cfg_div;
        pend_sps_d   = cfg_sps;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= DEF_DIV;
      sps_q        <= DEF_SPS;
      pend_div_q   <= '0;
      pend_sps_q   <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sps_q        <= sps_d;
      pend_div_q   <= pend_div_d;
      pend_sps_q   <= pend_sps_d;
      pend_valid_q <= pend_valid_d;
    end
  end

`ifdef SYM_TICK_SCHED_UNDERRUN_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (cfg_fire)                             underrun_d = 1'b0;
    else if (symbol_tick && !sym_data_valid) underrun_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) underrun_q <= 1'b0;
    else     underrun_q <= underrun_d;
  end

  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_sym_tick_sched.sv
// Scoreboard bench for sym_tick_sched: directed scenarios push expected tick
// times into a queue, a negedge monitor pops and compares them.
module tb_sym_tick_sched;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [12:0] cfg_div = '0;
  logic [7:0]  cfg_sps = '0;
  logic        sample_tick, symbol_tick, busy;
`ifdef SYM_TICK_SCHED_UNDERRUN_EN
  logic        sym_data_valid = 1'b1;
  logic        underrun;
`endif

  sym_tick_sched dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .en             (en),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_div        (cfg_div),
    .cfg_sps        (cfg_sps),
    .sample_tick    (sample_tick),
    .symbol_tick    (symbol_tick),
`ifdef SYM_TICK_SCHED_UNDERRUN_EN
    .sym_data_valid (sym_data_valid),
    .underrun       (underrun),
`endif
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit sym;
  } tick_t;
  tick_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_tick(input int c, input bit s);
    tick_t e;
    e.cyc = c;
    e.sym = s;
    exp_q.push_back(e);
  endtask

  task automatic push_ticks(input int first, input int spacing, input int n, input int sps);
    for (int i = 0; i < n; i++) push_tick(first + i * spacing, (i % sps) == 0);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // Monitor: compares every cycle on which the DUT ticks or a tick is due.
  always @(negedge clk_in) begin
    tick_t e;
    bit    exp_now;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("tick_missing", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (sample_tick || exp_now) begin
      check("sample_tick", sample_tick, exp_now);
      if (exp_now) begin
        e = exp_q.pop_front();
        if (sample_tick) check("symbol_tick", symbol_tick, e.sym);
      end
    end else if (symbol_tick) begin
      check("symbol_without_sample", symbol_tick, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int t;

  initial begin
    rst = 1'b1;
    #1;
    check("rst_sample_tick", sample_tick, 0);
    check("rst_symbol_tick", symbol_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    step(); step();
    rst = 1'b0;

    // 1: div=4 sps=3, stop mid-symbol and drain.
    step(); t = cyc;
    cfg_valid = 1'b1; cfg_div = 13'd4; cfg_sps = 8'd3; en = 1'b1;
    push_ticks(t + 4, 4, 9, 3);
    step(); cfg_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_cfg_ready", cfg_ready, 1);
    wait_until(t + 29); en = 1'b0;
    wait_until(t + 36); check("t1_drain_busy", busy, 1);
    wait_until(t + 37); check("t1_idle", busy, 0);
    wait_until(t + 40); check("t1_queue_empty", exp_q.size(), 0);

    // 2: zero factors clamp to one -> tick every cycle, every tick a symbol.
    step(); t = cyc;
    cfg_valid = 1'b1; cfg_div = 13'd0; cfg_sps = 8'd0; en = 1'b1;
    push_ticks(t + 1, 1, 4, 1);
    step(); cfg_valid = 1'b0;
    wait_until(t + 4); en = 1'b0;
    wait_until(t + 5); check("t2_idle", busy, 0);
    wait_until(t + 8); check("t2_queue_empty", exp_q.size(), 0);

    // 3: reprogram mid-symbol; new rate starts at the next symbol boundary.
    step(); t = cyc;
    cfg_valid = 1'b1; cfg_div = 13'd2; cfg_sps = 8'd4; en = 1'b1;
    push_tick(t + 2, 1);  push_tick(t + 4, 0);  push_tick(t + 6, 0);  push_tick(t + 8, 0);
    push_tick(t + 13, 1); push_tick(t + 18, 0); push_tick(t + 23, 1); push_tick(t + 28, 0);
    step(); cfg_valid = 1'b0;
    wait_until(t + 4); cfg_valid = 1'b1; cfg_div = 13'd5; cfg_sps = 8'd2;
    wait_until(t + 5); cfg_valid = 1'b0;
    check("t3_ready_low", cfg_ready, 0);
    wait_until(t + 8); check("t3_ready_hold", cfg_ready, 0);
    wait_until(t + 9); check("t3_ready_back", cfg_ready, 1);
    wait_until(t + 29); en = 1'b0;
    wait_until(t + 30); check("t3_idle", busy, 0);
    wait_until(t + 32); check("t3_queue_empty", exp_q.size(), 0);

    // 4a: div=3 sps=4, stop after 2nd sample -> exactly 2 more ticks.
    step(); t = cyc;
    cfg_valid = 1'b1; cfg_div = 13'd3; cfg_sps = 8'd4; en = 1'b1;
    push_ticks(t + 3, 3, 4, 4);
    step(); cfg_valid = 1'b0;
    wait_until(t + 7); en = 1'b0;
    wait_until(t + 8);  check("t4a_drain", busy, 1);
    wait_until(t + 12); check("t4a_drain_last", busy, 1);
    wait_until(t + 13); check("t4a_idle", busy, 0);
    wait_until(t + 16); check("t4a_queue_empty", exp_q.size(), 0);

    // 4b: re-raise en during DRAIN -> tick spacing unbroken.
    step(); t = cyc;
    en = 1'b1;
    push_ticks(t + 3, 3, 8, 4);
    wait_until(t + 7); en = 1'b0;
    wait_until(t + 8); en = 1'b1;
    wait_until(t + 24); check("t4b_busy", busy, 1);
    wait_until(t + 25); en = 1'b0;
    wait_until(t + 26); check("t4b_idle", busy, 0);
    wait_until(t + 28); check("t4b_queue_empty", exp_q.size(), 0);

    // 5: reset mid-DRAIN with a pending config; defaults come back.
    step(); t = cyc;
    en = 1'b1;
    push_tick(t + 3, 1); push_tick(t + 6, 0);
    wait_until(t + 4); cfg_valid = 1'b1; cfg_div = 13'd7; cfg_sps = 8'd5;
    wait_until(t + 5); cfg_valid = 1'b0;
    check("t5_ready_low", cfg_ready, 0);
    wait_until(t + 7); en = 1'b0;
    wait_until(t + 9);
    check("t5_pre_rst_tick", sample_tick, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_sample_tick", sample_tick, 0);
    check("t5_rst_symbol_tick", symbol_tick, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cfg_ready", cfg_ready, 1);
    step(); step();
    rst = 1'b0;
    step(); t = cyc;
    en = 1'b1;
    push_ticks(t + 4, 4, 8, 8);
    wait_until(t + 33); en = 1'b0;
    wait_until(t + 34); check("t5_idle", busy, 0);
    wait_until(t + 36); check("t5_queue_empty", exp_q.size(), 0);

`ifdef SYM_TICK_SCHED_UNDERRUN_EN
    // 6: sticky underrun, cleared by an accepted config.
    step(); t = cyc;
    check("t6_underrun_init", underrun, 0);
    cfg_valid = 1'b1; cfg_div = 13'd2; cfg_sps = 8'd2; en = 1'b1; sym_data_valid = 1'b0;
    push_tick(t + 2, 1); push_tick(t + 4, 0); push_tick(t + 6, 1); push_tick(t + 8, 0);
    step(); cfg_valid = 1'b0;
    wait_until(t + 2); check("t6_underrun_before", underrun, 0);
    wait_until(t + 3); check("t6_underrun_set", underrun, 1);
    sym_data_valid = 1'b1;
    wait_until(t + 7); check("t6_underrun_sticky", underrun, 1);
    wait_until(t + 9); en = 1'b0;
    wait_until(t + 10); check("t6_idle", busy, 0);
    cfg_valid = 1'b1; cfg_div = 13'd4; cfg_sps = 8'd8;
    wait_until(t + 11); cfg_valid = 1'b0;
    check("t6_underrun_clear", underrun, 0);
    wait_until(t + 13); check("t6_queue_empty", exp_q.size(), 0);
`endif

    step(); step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
